// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage -- pipeline stage register with valid/ready handshake and
// a 2-entry skid buffer. It carries an instruction word, a PC and NUM_OPS
// operand fields between two CPU datapath stages. in_ready is decoded from
// the state register only, so full throughput needs no combinational path
// from out_ready back to in_ready.
//
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cnt and
// bubble_cnt performance counters and their ports.
//
// Ports:
//   clk         rising-edge clock
//   res         synchronous active-high reset (priority over flush)
//   flush       kill stage contents; the stage becomes a bubble
//   in_valid    upstream beat valid
//   in_ready    stage can accept a beat (state != FULL)
//   in_command  instruction word
//   in_pc       instruction PC
//   in_ops      packed operands, op0 in [OP_W-1:0]
//   out_valid   downstream beat valid (state != EMPTY)
//   out_ready   downstream accepts
//   out_command head instruction word (0 when out_valid=0)
//   out_pc      head PC (0 when out_valid=0)
//   out_ops     head operands (0 when out_valid=0)
//   occupancy   entries held, 0..2
//   stall_cnt   cycles with out_valid=1 and out_ready=0 (saturating)
//   bubble_cnt  cycles with out_valid=0 (saturating)
module pipe_skid_stage #(
   parameter int OP_W    = 32,
   parameter int NUM_OPS = 3,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_command,
   input  logic [PC_W-1:0]         in_pc,
   input  logic [NUM_OPS*OP_W-1:0] in_ops,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_command,
   output logic [PC_W-1:0]         out_pc,
   output logic [NUM_OPS*OP_W-1:0] out_ops,
   output logic [1:0]              occupancy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                    state;
   logic                      in_fire;
   logic                      out_fire;

   // Main entry drives the outputs; skid entry absorbs the beat accepted
   // while the head is stalled.
   logic [31:0]               main_cmd_p1;
   logic [PC_W-1:0]           main_pc_p1;
   logic [NUM_OPS*OP_W-1:0]   main_ops_p1;
   logic [31:0]               skid_cmd_p1;
   logic [PC_W-1:0]           skid_pc_p1;
   logic [NUM_OPS*OP_W-1:0]   skid_ops_p1;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign occupancy = state;

   // Main is zeroed whenever the stage empties, so the bubble outputs are
   // all-zero without any output-side gating.
   assign out_command = main_cmd_p1;
   assign out_pc      = main_pc_p1;
   assign out_ops     = main_ops_p1;

   // ---- input -> p1 (main/skid entries) ----
   always_ff @(posedge clk) begin
      if (res || flush) begin
         state       <= EMPTY;
         main_cmd_p1 <= '0;
         main_pc_p1  <= '0;
         main_ops_p1 <= '0;
         skid_cmd_p1 <= '0;
         skid_pc_p1  <= '0;
         skid_ops_p1 <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state       <= BUSY;
                  main_cmd_p1 <= in_command;
                  main_pc_p1  <= in_pc;
                  main_ops_p1 <= in_ops;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_cmd_p1 <= in_command;
                  main_pc_p1  <= in_pc;
                  main_ops_p1 <= in_ops;
               end else if (in_fire) begin
                  state       <= FULL;
                  skid_cmd_p1 <= in_command;
                  skid_pc_p1  <= in_pc;
                  skid_ops_p1 <= in_ops;
               end else if (out_fire) begin
                  state       <= EMPTY;
                  main_cmd_p1 <= '0;
                  main_pc_p1  <= '0;
                  main_ops_p1 <= '0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state       <= BUSY;
                  main_cmd_p1 <= skid_cmd_p1;
                  main_pc_p1  <= skid_pc_p1;
                  main_ops_p1 <= skid_ops_p1;
               end
            end
            default: begin
               state       <= EMPTY;
               main_cmd_p1 <= '0;
               main_pc_p1  <= '0;
               main_ops_p1 <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Counters look at the pre-edge state, so a flush cycle is counted by
   // what the stage held before the kill. Only res clears them.
   always_ff @(posedge clk) begin
      if (res) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
         if (!out_valid)              bubble_cnt <= sat_inc(bubble_cnt);
      end
   end
`else
   // CNT_W only sizes the perf counters; without them it has no effect.
   if (CNT_W > 0) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register for the CPU datapath: carries instruction word, PC and NUM_OPS operand fields between two stages.
- Replaces the plain enable-gated stage register with a valid/ready handshake and a 2-entry skid buffer, giving full throughput with a registered in_ready.
- Synchronous flush converts the stage to a bubble (command 0 = nop) for branch/exception kill.

Parameters:
- OP_W, 32, width of one operand field (RD1/RD2/EXT-style values)
- NUM_OPS, 3, number of operand fields carried, packed LSB-first (op0 in [OP_W-1:0])
- PC_W, 32, PC field width
- CNT_W, 32, perf counter width (used only with PIPE_PERF_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- res  in  1  synchronous active-high reset
- flush  in  1  kill stage contents this cycle
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_command  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- in_ops  in  NUM_OPS*OP_W  packed operands
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_command  out  32  head instruction word
- out_pc  out  PC_W  head PC
- out_ops  out  NUM_OPS*OP_W  head operands
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  (PIPE_PERF_CNT_EN only) cycles out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  (PIPE_PERF_CNT_EN only) cycles out_valid=0

Behaviour:
- One clock clk; reset res is synchronous and active-high.
- Storage: main entry (drives outputs) and skid entry. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), BUSY (occ 1), FULL (occ 2). occupancy is the encoded state.
- EMPTY: in_fire -> BUSY, main <= in.
- BUSY: in_fire & out_fire -> BUSY, main <= in; in_fire & !out_fire -> FULL, skid <= in; !in_fire & out_fire -> EMPTY; neither -> hold.
- FULL: in_ready=0 so no in_fire; out_fire -> BUSY, main <= skid; else hold.
- in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready.
- out_valid = (state != EMPTY). Outputs are the main entry, registered; latency 1 cycle when empty.
- Bubble rule: whenever out_valid=0, out_command, out_pc and out_ops are all 0. Main is cleared on any transition into EMPTY.
- Held data is stable: while out_valid=1 and out_ready=0, outputs do not change.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush/res.
- flush=1: next state EMPTY, main and skid cleared to 0; any same-cycle in_fire is discarded. in_ready still follows the current state. Flush has priority over the handshake; res has priority over flush.
- res=1: state EMPTY, all data 0, occupancy 0, counters 0. Reset mid-transfer discards both entries.
- Widths: fields are copied bit-exact; no arithmetic on data.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cnt and bubble_cnt ports exist. Each increments by 1 per qualifying cycle, saturates at all-ones, and is cleared by res only (flush does not clear them). A flush cycle counts by its pre-flush state.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold res=1 with in_valid=1, in_command=0x12345678 -> after release, out_valid=0, outputs 0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with PCs 0x3000, 0x3004, 0x3008, 0x300C -> same PCs appear on consecutive cycles, one cycle later, in order; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0 while beats A(0x3000), B(0x3004), C(0x3008) are offered -> A and B accepted, occupancy=2, in_ready=0, C held upstream, out_pc stable at 0x3000. Then out_ready=1 -> sequence A, B, C with no loss.
- Flush when full: occupancy=2 and flush=1 with in_valid=1 -> next cycle out_valid=0, all outputs 0, occupancy=0, new beat not stored.
- Priority: res=1 and flush=1 together while BUSY -> reset state. With PIPE_PERF_CNT_EN, counters read 0.
- Perf counters (PIPE_PERF_CNT_EN): 5 stall cycles and 3 empty cycles -> stall_cnt=5, bubble_cnt=3. With CNT_W=4 and 20 stall cycles -> stall_cnt=15 (saturated).
